// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module uart_rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  // Two passes: indices at/after ptr first, then the wrapped-around ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found && valid[j] && (IDX_W'(j) >= ptr)) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found && valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among N_REQ byte requesters.
// Optional frame lock: define UART_ARB_FRAME_LOCK_EN to hold the grant until req_last.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  localparam int unsigned IDX_W       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] rr_ptr, pick_idx, ptr_inc;
  logic [N_REQ-1:0] pick_valid, pick_grant;
  logic [DATA_W-1:0] pick_data;
  logic             xfer, tx_start_d, timeout_d, timeout_hit;

`ifdef UART_ARB_FRAME_LOCK_EN
  logic             lock_q;
  logic [IDX_W-1:0] lock_id;
  logic             pick_last;

  // While locked only the owning requester is visible to the picker.
  assign pick_valid = lock_q ? (req_valid & (N_REQ'(1) << lock_id)) : req_valid;
  assign pick_last  = |(req_last & pick_grant);
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign pick_valid  = req_valid;
`endif

  uart_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .valid     (pick_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign ptr_inc     = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign timeout_hit = (state == WAIT_BUSY) && (cnt == CNT_W'(BUSY_TIMEOUT));

  // Byte mux for the granted requester.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state, handshake and pulse decode.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    req_ready  = '0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && !rst) req_ready = pick_grant;
        xfer = |req_ready;
        if (xfer) begin
          state_d    = START;
          tx_start_d = 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d     = cnt + CNT_W'(1);
          timeout_d = (cnt_d == CNT_W'(BUSY_TIMEOUT));
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and latched outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      tx_start    <= tx_start_d;
      timeout_err <= timeout_d;
      if (xfer) begin
        tx_data  <= pick_data;
        grant_id <= pick_idx;
      end
    end
  end

`ifdef UART_ARB_FRAME_LOCK_EN
  // Lock tracking: engage on a non-last byte, release on last byte or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q  <= 1'b0;
      lock_id <= '0;
    end else if (xfer) begin
      lock_q  <= !pick_last;
      lock_id <= pick_idx;
    end else if (timeout_hit) begin
      lock_q  <= 1'b0;
    end
  end

  // Pointer moves only when a lock is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer && pick_last) begin
      rr_ptr <= ptr_inc;
    end else if (timeout_hit && lock_q) begin
      rr_ptr <= (lock_id == IDX_W'(N_REQ - 1)) ? '0 : lock_id + IDX_W'(1);
    end
  end
`else
  // Pointer moves past every granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_inc;
    end
  end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serializer among N byte requesters, such as the PC-forwarding path and a local status/ack generator, using round-robin arbitration. It accepts bytes over a valid/ready handshake and issues a one-cycle `tx_start` with latched `tx_data`. It then tracks `tx_busy` through the full character before granting again, so no byte is dropped while the serializer is busy. It sits between the requesters and the `uart_tx` instance in the FPGA1 simplex TX top.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `BUSY_TIMEOUT`, default 16: max cycles to wait for `tx_busy` rise after `tx_start`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester byte available.
- `req_data`  in  N_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- `req_last`  in  N_REQ  marks the last byte of a frame; used only with the frame-lock feature.
- `req_ready`  out  N_REQ  combinational, one-hot or zero; transfer occurs when `req_valid[i] && req_ready[i]`.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  DATA_W  byte to `uart_tx`, held stable from `tx_start` until return to IDLE.
- `tx_busy`  in  1  from `uart_tx`.
- `grant_id`  out  clog2(N_REQ)  index of the requester last accepted.
- `timeout_err`  out  1  one-cycle pulse when `tx_busy` fails to rise.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If `!tx_busy` and any `req_valid` is high, the picker selects the first valid requester at or after `rr_ptr`, wrapping modulo N_REQ.
  - `req_ready` is high for that requester only.
  - On transfer: latch `tx_data` and `grant_id`, set `rr_ptr = grant+1 mod N_REQ`, go to START.
- START: `tx_start = 1` for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - On `tx_busy = 1`, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`, pulse `timeout_err`, return to IDLE and drop the byte.
- WAIT_DONE: on `tx_busy = 0`, go to IDLE.
- `req_ready` is 0 in every state other than IDLE, and 0 in IDLE while `tx_busy = 1`.
- Simultaneous valids: exactly one grant per byte; each requester is served at most once per N_REQ grants while others are pending.
- A requester deasserting `req_valid` before transfer loses nothing; no request is latched without a transfer.
- Reset, asynchronous at any time including mid-character:
  - FSM returns to IDLE.
  - `rr_ptr` = 0, so requester 0 has highest priority after reset.
  - `tx_start` = 0, `tx_data` = 0, `grant_id` = 0, `timeout_err` = 0.
  - `req_ready` forced to 0 while `rst` is high.
  - Lock state cleared.

## Timing
- Transfer at edge T leads to `tx_start` high during cycle T+1. `tx_data` is valid from T+1.
- Minimum spacing between transfers is 3 cycles plus the `tx_busy` high duration.
- `tx_busy` may rise in the START cycle; WAIT_BUSY then exits on its first cycle.
- Timeout: `timeout_err` asserts in cycle T+2+BUSY_TIMEOUT when `tx_busy` never rises; IDLE follows on the next cycle.

## Configuration
- `UART_ARB_FRAME_LOCK_EN` defined:
  - After a transfer with `req_last[i] = 0`, the grant locks to requester i.
  - While locked, IDLE offers `req_ready` only to i; other requesters wait even if valid.
  - The lock releases after a transfer with `req_last[i] = 1`, or on timeout.
  - `rr_ptr` advances only on release.
- Not defined: `req_last` is ignored, and arbitration is per byte.

## Structure
- Package `uart_arb_pkg`: FSM state enum, `DATA_W_DEF = 8`, `BUSY_TIMEOUT_DEF = 16`.
- Sub-module `uart_rr_picker`: combinational round-robin picker. Inputs are the valid vector and the pointer; outputs are a one-hot grant and its index.

## Test plan
- Single requester: req0 sends 0x41; `uart_tx` model raises busy for 20 cycles. Expect `tx_start` once, `tx_data = 0x41`, `req_ready[0]` for 1 cycle, next accept no earlier than busy fall + 1.
- Contention: req0 and req1 both hold valid with 0x11 and 0x22 continuously after reset. Expect grant order 0,1,0,1, and `tx_data` alternating 0x11/0x22.
- Timeout: `tx_busy` tied 0; req1 sends 0x55. Expect `timeout_err` pulse at transfer + 18 cycles, return to IDLE, and the next request accepted.
- Busy at idle: `tx_busy` held 1 while req0 is valid. Expect `req_ready` = 0 until `tx_busy` falls, then accept.
- Reset mid-character: assert `rst` during WAIT_DONE. Expect all outputs 0, then after release req0 wins over req1.
- Frame lock, macro defined: req0 sends 3 bytes with last on the 3rd while req1 is valid throughout. Expect req0, req0, req0, then req1.
